// File: rtl/cmem_cp_sequencer.sv
// Amiga clockport bus to cmem single-cycle read/write strobe sequencer.
// Optional glitch filter on strobe acceptance: define CMEM_CP_GLITCH_FILTER_EN.
module cmem_cp_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4,
  parameter int FILTER      = 3
) (
  input  logic       clk200,
  input  logic       reset,
  input  logic       CP_CS_n,
  input  logic       CP_RD_n,
  input  logic       CP_WR_n,
  input  logic [3:0] CP_A,
  input  logic [3:0] CP_D_in,
  output logic [3:0] CP_D_out,
  output logic       CP_D_oe,
  output logic       cp_read,
  output logic       cp_write,
  output logic [3:0] cp_address,
  output logic [3:0] cp_out_cmem_in,
  input  logic [3:0] cp_in_cmem_out,
  output logic       cp_error
);

  if (SYNC_STAGES < 2 || SETTLE < 1 || SETTLE > 15 || FILTER < 1 || FILTER > 7) begin : g_bad_param
    $error("cmem_cp_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

  localparam logic [3:0] SLAST = 4'(SETTLE - 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic                   rd_act, wr_act, act;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       armed_q, armed_d;
  logic       err_q, err_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic [3:0] dout_q, dout_d;
  logic       oe_q, oe_d;
`ifdef CMEM_CP_GLITCH_FILTER_EN
  localparam logic [2:0] FLAST = 3'(FILTER - 1);
  logic [2:0] fcnt_q, fcnt_d;
`endif

  // Synchronizers carry no reset: armed, not the chain, decides acceptance after reset.
  always_ff @(posedge clk200) begin
    cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], CP_CS_n};
    rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], CP_RD_n};
    wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], CP_WR_n};
  end

  assign rd_act = !cs_sync_q[SYNC_STAGES-1] && !rd_sync_q[SYNC_STAGES-1];
  assign wr_act = !cs_sync_q[SYNC_STAGES-1] && !wr_sync_q[SYNC_STAGES-1];
  assign act    = rd_act || wr_act;

  always_ff @(posedge clk200) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
`ifdef CMEM_CP_GLITCH_FILTER_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
`ifdef CMEM_CP_GLITCH_FILTER_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    armed_d = armed_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
`ifdef CMEM_CP_GLITCH_FILTER_EN
    fcnt_d  = fcnt_q;
`endif
    if (!act) armed_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_act && wr_act) begin
          err_d   = 1'b1;
          armed_d = 1'b0;
`ifdef CMEM_CP_GLITCH_FILTER_EN
          fcnt_d  = '0;
`endif
        end else if (armed_q && act) begin
`ifdef CMEM_CP_GLITCH_FILTER_EN
          // A direction flip mid-count restarts the run with this cycle counted.
          dir_d = rd_act;
          if (fcnt_q != 3'd0 && rd_act != dir_q) begin
            fcnt_d = 3'd1;
          end else if (fcnt_q == FLAST) begin
            state_d = S_SETTLE;
            armed_d = 1'b0;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 3'd1;
          end
`else
          state_d = S_SETTLE;
          dir_d   = rd_act;
          armed_d = 1'b0;
`endif
        end
`ifdef CMEM_CP_GLITCH_FILTER_EN
        else begin
          fcnt_d = '0;
        end
`endif
      end
      S_SETTLE: begin
        if (!(dir_q ? (rd_act && !wr_act) : (wr_act && !rd_act))) begin
          state_d = S_IDLE;
        end else if (cnt_q == SLAST) begin
          addr_d  = CP_A;
          wdata_d = CP_D_in;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ISSUE: state_d = dir_q ? S_CAPTURE : S_HOLD;
      S_CAPTURE: begin
        dout_d  = cp_in_cmem_out;
        oe_d    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!act) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cp_read  = (state_q == S_ISSUE) &&  dir_q;
    cp_write = (state_q == S_ISSUE) && !dir_q;
  end

  assign cp_address     = addr_q;
  assign cp_out_cmem_in = wdata_q;
  assign CP_D_out       = dout_q;
  assign CP_D_oe        = oe_q;
  assign cp_error       = err_q;

endmodule

// File: tb/tb_cmem_cp_sequencer.sv
// Directed bench for cmem_cp_sequencer with a small cmem reg-10 shift-out model.
`timescale 1ns/1ps
module tb_cmem_cp_sequencer;

`ifdef CMEM_CP_GLITCH_FILTER_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 7;
`endif

  logic       clk200 = 1'b0;
  logic       reset;
  logic       CP_CS_n, CP_RD_n, CP_WR_n;
  logic [3:0] CP_A, CP_D_in;
  logic [3:0] CP_D_out;
  logic       CP_D_oe;
  logic       cp_read, cp_write;
  logic [3:0] cp_address, cp_out_cmem_in;
  logic [3:0] cp_in_cmem_out;
  logic       cp_error;

  cmem_cp_sequencer dut (
    .clk200(clk200), .reset(reset),
    .CP_CS_n(CP_CS_n), .CP_RD_n(CP_RD_n), .CP_WR_n(CP_WR_n),
    .CP_A(CP_A), .CP_D_in(CP_D_in),
    .CP_D_out(CP_D_out), .CP_D_oe(CP_D_oe),
    .cp_read(cp_read), .cp_write(cp_write),
    .cp_address(cp_address), .cp_out_cmem_in(cp_out_cmem_in),
    .cp_in_cmem_out(cp_in_cmem_out), .cp_error(cp_error)
  );

  always #5 clk200 = ~clk200;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk200) cyc <= cyc + 1;

  // cmem stand-in: reg 10 shifts out 20'h00001 a nibble per read.
  logic [19:0] sr = 20'h00001;
  always @(posedge clk200) begin
    if (cp_read) begin
      if (cp_address == 4'd10) begin
        cp_in_cmem_out <= sr[3:0];
        sr <= sr >> 4;
      end else begin
        cp_in_cmem_out <= cp_address;
      end
    end
  end

  int rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0, viol = 0;
  int oe_rise = 0, oe_fall = 0;
  logic [3:0] rd_addr = 4'd0, wr_addr = 4'd0, wr_data = 4'd0;
  logic rd_prev = 1'b0, wr_prev = 1'b0, oe_prev = 1'b0;

  always @(negedge clk200) begin
    if (cp_read) begin rd_cnt++; rd_cyc = cyc; rd_addr = cp_address; end
    if (cp_write) begin wr_cnt++; wr_cyc = cyc; wr_addr = cp_address; wr_data = cp_out_cmem_in; end
    if ((cp_read && cp_write) || (cp_read && rd_prev) || (cp_write && wr_prev)) viol++;
    if (CP_D_oe && !oe_prev) oe_rise = cyc;
    if (!CP_D_oe && oe_prev) oe_fall = cyc;
    rd_prev = cp_read;
    wr_prev = cp_write;
    oe_prev = CP_D_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk200);
  endtask

  task automatic bus(input logic cs, input logic rd, input logic wr, input logic [3:0] a, input logic [3:0] d);
    CP_CS_n = cs; CP_RD_n = rd; CP_WR_n = wr; CP_A = a; CP_D_in = d;
  endtask

  logic [3:0] exp_rd [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    int t0, t1, r0, w0;
    reset = 1'b1;
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(3);
    chk("rst_read", cp_read, 0);
    chk("rst_write", cp_write, 0);
    chk("rst_addr", cp_address, 0);
    chk("rst_oe", CP_D_oe, 0);
    chk("rst_err", cp_error, 0);

    // Write reg 15 = 3
    t0 = cyc;
    bus(1'b0, 1'b1, 1'b0, 4'd15, 4'd3);
    wait_cyc(20);
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(10);
    chk("wr_count", wr_cnt, 1);
    chk("wr_no_read", rd_cnt, 0);
    chk("wr_latency", wr_cyc - t0, LAT);
    chk("wr_addr", wr_addr, 15);
    chk("wr_data", wr_data, 3);

    // Five reads of reg 10
    for (int i = 0; i < 5; i++) begin
      t0 = cyc;
      bus(1'b0, 1'b0, 1'b1, 4'd10, 4'd0);
      wait_cyc(15);
      chk("rd10_data", CP_D_out, exp_rd[i]);
      chk("rd10_oe_rise", oe_rise - rd_cyc, 2);
      t1 = cyc;
      bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
      wait_cyc(8);
      chk("rd10_oe_fall", oe_fall - t1, 3);
    end
    chk("rd10_count", rd_cnt, 5);

    // RD and WR together under CS
    r0 = rd_cnt; w0 = wr_cnt;
    bus(1'b0, 1'b0, 1'b0, 4'd2, 4'd9);
    wait_cyc(12);
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(6);
    chk("err_set", cp_error, 1);
    chk("err_no_rd", rd_cnt, r0);
    chk("err_no_wr", wr_cnt, w0);
    bus(1'b0, 1'b1, 1'b0, 4'd1, 4'd5);
    wait_cyc(20);
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(8);
    chk("err_wr_count", wr_cnt, w0 + 1);
    chk("err_wr_addr", wr_addr, 1);
    chk("err_sticky", cp_error, 1);

    // Reset during SETTLE while RD stays low
    r0 = rd_cnt;
    bus(1'b0, 1'b0, 1'b1, 4'd3, 4'd0);
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(1);
    chk("rs_err_clr", cp_error, 0);
    chk("rs_addr_clr", cp_address, 0);
    chk("rs_dout_clr", CP_D_out, 0);
    wait_cyc(20);
    chk("rs_no_read", rd_cnt, r0);
    CP_RD_n = 1'b1;
    wait_cyc(4);
    CP_RD_n = 1'b0;
    wait_cyc(15);
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(8);
    chk("rs_one_read", rd_cnt, r0 + 1);
    chk("rs_read_addr", rd_addr, 3);

    // Two-cycle glitch on WR
    r0 = rd_cnt; w0 = wr_cnt;
    bus(1'b0, 1'b1, 1'b0, 4'd7, 4'd7);
    wait_cyc(2);
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(12);
    chk("glitch_no_wr", wr_cnt, w0);
    chk("glitch_no_rd", rd_cnt, r0);
    chk("glitch_no_err", cp_error, 0);

    // Back-to-back reads with CS held low
    r0 = rd_cnt;
    bus(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(4);
    for (int i = 0; i < 3; i++) begin
      CP_A = 4'(12 + i);
      CP_RD_n = 1'b0;
      wait_cyc(12);
      CP_RD_n = 1'b1;
      wait_cyc(4);
      chk("b2b_addr", rd_addr, 12 + i);
    end
    bus(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_cyc(6);
    chk("b2b_count", rd_cnt, r0 + 3);
    chk("strobe_shape", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
